// File: rtl/ta_sync_pkg.sv
// Shared state encodings and default timing constants for the capture arbiter.
// Optional statistics counters are enabled with TA_ARB_STATS_EN.
package ta_sync_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WLOW  = 3'd1;
    localparam state_t S_WHIGH = 3'd2;
    localparam state_t S_GUARD = 3'd3;
    localparam state_t S_TMO   = 3'd4;

    localparam int TO_CYC_DEF    = 50000;
    localparam int GUARD_CYC_DEF = 4;

endpackage

// File: rtl/ta_cap_arbiter_if.sv
// Requester/sync-side signal bundle of the capture arbiter.
// grant_cnt/tmo_cnt exist only when TA_ARB_STATS_EN is defined.
interface ta_cap_arbiter_if #(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] err;
    logic             cap_trig;
    logic             syncr_rdy;
    logic             busy;
`ifdef TA_ARB_STATS_EN
    logic [15:0]      grant_cnt;
    logic [7:0]       tmo_cnt;
`endif

    modport master (
        input  req, syncr_rdy,
`ifdef TA_ARB_STATS_EN
        output grant_cnt, tmo_cnt,
`endif
        output gnt, done, err, cap_trig, busy
    );

    modport slave (
        output req, syncr_rdy,
`ifdef TA_ARB_STATS_EN
        input  grant_cnt, tmo_cnt,
`endif
        input  gnt, done, err, cap_trig, busy
    );

endinterface

// File: rtl/ta_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// No configuration macros.
module ta_rr_pick
    import ta_sync_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx,
    output logic [N_REQ-1:0] onehot
);

    logic [PW-1:0] cand;

    // Scan farthest offset first so the nearest hit overwrites the rest.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        onehot = N_REQ'(any) << idx;
    end

endmodule

// File: rtl/ta_cap_arbiter.sv
// Round-robin arbiter sharing one capture/sync sequencer among N_REQ requesters.
// Define TA_ARB_STATS_EN to add grant_cnt/tmo_cnt statistics.
module ta_cap_arbiter
    import ta_sync_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TO_W      = 16,
    parameter int TO_CYC    = TO_CYC_DEF,
    parameter int GUARD_CYC = GUARD_CYC_DEF,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input logic              clk50,
    input logic              rst,
    ta_cap_arbiter_if.master bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0] G_LAST  = TO_W'(GUARD_CYC - 1);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;

    logic             pick_any;
    logic [PW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    idx_nxt;

    ta_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    assign idx_nxt = (idx_q == PW'(N_REQ - 1)) ? '0
                   : idx_q + PW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        trig_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any && bus.syncr_rdy) begin
                    idx_d   = pick_idx;
                    gnt_d   = pick_oh;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WLOW;
                end
            end
            // Only a low level counts here; staying high is not progress.
            S_WLOW: begin
                if (!bus.syncr_rdy) begin
                    cnt_d   = '0;
                    state_d = S_WHIGH;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TMO;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_WHIGH: begin
                if (bus.syncr_rdy) begin
                    cnt_d   = '0;
                    state_d = S_GUARD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TMO;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_GUARD: begin
                if (cnt_q == G_LAST) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = idx_nxt;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_TMO: begin
                err_d   = gnt_q;
                gnt_d   = '0;
                ptr_d   = idx_nxt;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cap_trig = trig_q;
    assign bus.busy     = busy_q;

`ifdef TA_ARB_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    // Completions wrap; timeouts stick at their maximum.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        if (|done_d) grant_cnt_d = grant_cnt_q + 16'd1;
        if (|err_d && tmo_cnt_q != 8'hff) tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
    assign bus.tmo_cnt   = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_ta_cap_arbiter.sv
// Randomized self-checking bench for ta_cap_arbiter with a sequence-level model.
// Stats checks are compiled in when TA_ARB_STATS_EN is defined.
module tb_ta_cap_arbiter;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int GC = 4;
    localparam int VW = 3 * N + 2;

    logic clk50 = 1'b0;
    logic rst   = 1'b0;

    always #5 clk50 = ~clk50;

    ta_cap_arbiter_if #(.N_REQ(N)) bus ();

    ta_cap_arbiter #(
        .N_REQ     (N),
        .TO_W      (16),
        .TO_CYC    (TO),
        .GUARD_CYC (GC)
    ) dut (
        .clk50 (clk50),
        .rst   (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int ptr_m     = 0;
    int n_done_m  = 0;
    int n_err_m   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] vec(input logic [N-1:0] g,
                                          input logic [N-1:0] d,
                                          input logic [N-1:0] e,
                                          input logic t,
                                          input logic b);
        return {g, d, e, t, b};
    endfunction

    function automatic logic [VW-1:0] obs();
        return vec(bus.gnt, bus.done, bus.err, bus.cap_trig, bus.busy);
    endfunction

    // Reference pick: lowest wrapped offset from ptr with a pending request.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic chk_stats();
`ifdef TA_ARB_STATS_EN
        chk("grant_cnt", 32'(bus.grant_cnt), 32'(n_done_m % 65536));
        chk("tmo_cnt", 32'(bus.tmo_cnt), 32'((n_err_m > 255) ? 255 : n_err_m));
`endif
    endtask

    // mode 0: sync drops after d, stays low L cycles, returns -> done
    // mode 1: sync never drops -> timeout waiting for low
    // mode 2: sync drops after d and never returns -> timeout waiting for high
    task automatic run_seq(input logic [N-1:0] r, input int mode,
                           input int d, input int len, input bit gdrop,
                           input bit mess, input int gap);
        int            idx;
        int            pre;
        int            e;
        logic [N-1:0]  oh;
        logic [VW-1:0] ex;
        bus.req = '0;
        for (int k = 0; k < gap; k++) begin
            @(negedge clk50);
            chk("idle_gap", 32'(obs()), 32'(0));
        end
        idx = pick(r, ptr_m);
        oh  = N'(1) << idx;
        pre = bus.syncr_rdy ? 0 : 1 + int'($urandom_range(0, 4));
        bus.req = r;
        for (int k = 1; k <= pre; k++) begin
            @(negedge clk50);
            chk("wait_rdy", 32'(obs()), 32'(0));
            if (k == pre) bus.syncr_rdy = 1'b1;
        end
        case (mode)
            0:       e = d + len + GC + 2;
            1:       e = TO + 2;
            default: e = d + TO + 3;
        endcase
        for (int k = 1; k <= e; k++) begin
            @(negedge clk50);
            if (k < e)
                ex = vec(oh, '0, '0, k == 1, 1'b1);
            else if (mode == 0)
                ex = vec('0, oh, '0, 1'b0, 1'b0);
            else
                ex = vec('0, '0, oh, 1'b0, 1'b0);
            chk(k == e ? "seq_end" : "seq_run", 32'(obs()), 32'(ex));
            if (mode != 1 && k == 1 + d) bus.syncr_rdy = 1'b0;
            if (mode == 0 && k == 1 + d + len) bus.syncr_rdy = 1'b1;
            if (mode == 0 && gdrop && k == 2 + d + len) bus.syncr_rdy = 1'b0;
            if (mess && k < e) bus.req = N'($urandom);
        end
        ptr_m = (idx + 1) % N;
        if (mode == 0) n_done_m++;
        else n_err_m++;
        chk_stats();
    endtask

    initial begin
        logic [N-1:0] r;
        int           mode;
        bus.req       = '0;
        bus.syncr_rdy = 1'b1;
        #1 rst = 1'b1;
        #2 chk("reset_async", 32'(obs()), 32'(0));
        @(negedge clk50);
        chk("reset_hold", 32'(obs()), 32'(0));
        chk_stats();
        rst = 1'b0;

        run_seq(4'b0010, 0, 3, 10, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++)
            run_seq(4'b1111, 0, int'($urandom_range(0, 5)),
                    int'($urandom_range(1, 6)), 1'b0, 1'b0, 0);
        run_seq(4'b0100, 1, 0, 0, 1'b0, 1'b0, 1);
        run_seq(4'b1000, 2, 2, 0, 1'b0, 1'b0, 0);
        run_seq(4'b0001, 0, 0, 1, 1'b0, 1'b0, 0);

        // Reset while the sync side is mid-sequence.
        bus.req = 4'b0100;
        @(negedge clk50);
        chk("rst_pre_gnt", 32'(bus.gnt), 32'(4'b0100));
        bus.syncr_rdy = 1'b0;
        repeat (3) @(negedge clk50);
        chk("rst_pre_busy", 32'(bus.busy), 32'(1));
        #2 rst = 1'b1;
        #1 chk("rst_mid_whigh", 32'(obs()), 32'(0));
        @(negedge clk50);
        bus.req       = '0;
        bus.syncr_rdy = 1'b1;
        rst           = 1'b0;
        ptr_m         = 0;
        n_done_m      = 0;
        n_err_m       = 0;
        chk_stats();
        run_seq(4'b1111, 0, 1, 2, 1'b0, 1'b0, 0);
        run_seq(4'b0001, 0, 0, 3, 1'b0, 1'b0, 1);
        run_seq(4'b1010, 0, 4, 1, 1'b0, 1'b0, 0);
        run_seq(4'b0110, 1, 0, 0, 1'b0, 1'b0, 0);
`ifdef TA_ARB_STATS_EN
        chk("stats_done3", 32'(bus.grant_cnt), 32'(3));
        chk("stats_tmo1", 32'(bus.tmo_cnt), 32'(1));
`endif

        for (int i = 0; i < 60; i++) begin
            r    = N'($urandom_range(1, (1 << N) - 1));
            mode = ($urandom_range(0, 5) < 4) ? 0
                 : int'($urandom_range(1, 2));
            run_seq(r, mode, int'($urandom_range(0, TO - 1)),
                    int'($urandom_range(1, TO)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
